// File: rtl/ysyx_24110015_icache.sv
// rtl/ysyx_24110015_icache.sv - direct-mapped read-only icache with AXI4 burst refill; ICACHE_PERF_EN adds perf_hit/perf_miss
module ysyx_24110015_icache #(
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_addr,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    input  logic        resp_ready,
    input  logic        flush,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic [3:0]  rid
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] perf_hit,
    output logic [31:0] perf_miss
`endif
);
    localparam int WOFF_W = $clog2(LINE_WORDS);
    localparam int OFF_W  = WOFF_W + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_AR, S_R, S_RESP} state_t;
    state_t state, state_nx;

    logic [31:0]                  addr_q, araddr_q, resp_q;
    logic [7:0]                   arlen_q;
    logic [WOFF_W-1:0]            beat_cnt;
    logic                         err_q, pend_flush;
    logic [SETS-1:0]              valid_q;
    logic [TAG_W-1:0]             tag_arr [SETS];
    logic [LINE_WORDS-1:0][31:0]  line_buf;
    logic [LINE_WORDS-1:0][31:0]  rd_words;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WOFF_W-1:0] woff, want_idx;
    logic              cacheable, hit, beat, beat_err, err_nx, install, enter_idle, flush_now;

    assign idx       = addr_q[OFF_W+IDX_W-1:OFF_W];
    assign tag       = addr_q[31:OFF_W+IDX_W];
    assign woff      = addr_q[OFF_W-1:2];
    assign cacheable = |addr_q[31:29];
    assign hit       = cacheable && valid_q[idx] && (tag_arr[idx] == tag);
    assign want_idx  = cacheable ? woff : '0;
    assign beat      = (state == S_R) && rvalid;

    // rlast must land exactly on beat arlen; a missing rlast there marks the burst as too long
    assign beat_err  = (rresp != 2'b00) ||
                       (rlast ? (8'(beat_cnt) != arlen_q) : (8'(beat_cnt) == arlen_q));
    assign err_nx    = err_q || beat_err;
    assign install   = beat && rlast && cacheable && !err_nx && !pend_flush && !flush;
    assign enter_idle = (state != S_IDLE) && (state_nx == S_IDLE);
    assign flush_now = ((state == S_IDLE) && flush) || (enter_idle && (flush || pend_flush));

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) state_nx = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (hit) begin
                    resp_valid = 1'b1;
                    if (resp_ready) state_nx = S_IDLE;
                end else begin
                    state_nx = S_AR;
                end
            end
            S_AR: begin
                arvalid = 1'b1;
                if (arready) state_nx = S_R;
            end
            S_R: begin
                rready = 1'b1;
                if (rvalid && rlast) state_nx = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            resp_q     <= '0;
            beat_cnt   <= '0;
            err_q      <= 1'b0;
            pend_flush <= 1'b0;
            valid_q    <= '0;
        end else begin
            state <= state_nx;
            if ((state == S_IDLE) && req_valid && !flush) addr_q <= req_addr;
            if ((state == S_LOOKUP) && !hit) begin
                araddr_q <= cacheable ? {addr_q[31:OFF_W], {OFF_W{1'b0}}} : {addr_q[31:2], 2'b00};
                arlen_q  <= cacheable ? 8'(LINE_WORDS - 1) : 8'd0;
                beat_cnt <= '0;
                err_q    <= 1'b0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
                err_q    <= err_nx;
                if ((beat_cnt == want_idx) && !err_q) resp_q <= rdata;
            end
            if (flush_now) begin
                valid_q    <= '0;
                pend_flush <= 1'b0;
            end else begin
                if (flush && (state != S_IDLE)) pend_flush <= 1'b1;
                if (install) valid_q[idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (beat) line_buf[beat_cnt] <= rdata;
        if (install) tag_arr[idx] <= tag;
    end

    // the final beat goes straight into the array since it never passes through line_buf
    for (genvar w = 0; w < LINE_WORDS; w++) begin : g_word
        logic [31:0] word_arr [SETS];
        always_ff @(posedge clk) begin
            if (install) word_arr[idx] <= (beat_cnt == WOFF_W'(w)) ? rdata : line_buf[w];
        end
        assign rd_words[w] = word_arr[idx];
    end

    assign resp_data = (state == S_LOOKUP) ? rd_words[woff] : resp_q;
    assign resp_err  = (state == S_RESP) && err_q;
    assign araddr    = araddr_q;
    assign arlen     = arlen_q;
    assign arid      = 4'd0;
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;

    logic unused_bits;
    assign unused_bits = ^{rid, addr_q[1:0]};

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt, miss_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if ((state == S_LOOKUP) && hit && resp_ready && (hit_cnt != '1)) hit_cnt <= hit_cnt + 1'b1;
            if ((state == S_AR) && arready && cacheable && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
        end
    end
    assign perf_hit  = hit_cnt;
    assign perf_miss = miss_cnt;
`endif
endmodule

// File: doc/ysyx_24110015_icache.md
Name: ysyx_24110015_icache

Overview:
- Direct-mapped, read-only instruction cache between the IFU fetch port and the IFU port of the AXI arbiter.
- Accepts one fetch request at a time and returns one 32-bit instruction word.
- On a miss, refills a full line with one AXI4 INCR burst. Device-space addresses bypass the cache with single-beat reads.
- Invalidates the whole cache on fence.i.

Parameters:
- LINE_WORDS, 4: 32-bit words per line. Power of 2, ≥2. Byte offset is addr[log2(LINE_WORDS)+1:0].
- SETS, 16: number of lines. Power of 2. Index field sits directly above the offset; tag is the remaining upper bits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (all state clears while rst=0).
- req_valid  in  1  fetch request from IFU.
- req_addr  in  32  fetch PC; bits [1:0] are ignored.
- req_ready  out  1  cache can accept a request.
- resp_valid  out  1  instruction word available.
- resp_data  out  32  instruction word.
- resp_err  out  1  bus error on this fetch.
- resp_ready  in  1  IFU consumes the response.
- flush  in  1  fence.i invalidate-all pulse.
- arvalid, arready, araddr[32], arid[4], arlen[8], arsize[3], arburst[2]: AXI4 AR channel, master side.
- rvalid, rready, rdata[32], rresp[2], rlast, rid[4]: AXI4 R channel, master side.

Behaviour:
- Reset values: state IDLE; all valid bits 0; req_ready=1; resp_valid=0, resp_data=0, resp_err=0; arvalid=0, rready=0, araddr=0; pending-flush flag 0.
- Fixed AXI fields: arid=0, arsize=3'b010, arburst=2'b01.
- Cacheable region: addr[31:29]!=3'b000. Addresses 0x0000_0000–0x1FFF_FFFF are uncached.
- Registers:
  - Request address is latched on req_valid&req_ready.
  - Data and tag arrays are flops, read combinationally with the latched index.
- FSM states:
  - IDLE: req_ready=1. On handshake, go to LOOKUP.
  - LOOKUP: req_ready=0.
    - Cached hit (valid&tag match): drive resp_valid=1 and resp_data=word from the array in this same cycle. Hit latency is 1 cycle after accept.
    - Cached miss: go to AR with araddr = line-aligned address, arlen=LINE_WORDS-1.
    - Uncached: go to AR with araddr = {addr[31:2],2'b00}, arlen=0.
  - AR: arvalid=1, held stable until arready. Then go to R.
  - R: rready=1. Each beat is written to the line buffer at beat counter index; counter wraps at LINE_WORDS.
    - On rlast: if every rresp==0 and beat count == arlen+1, install the line (set valid, write tag).
    - Uncached accesses never install.
    - Then go to RESP with resp_data = requested word (beat at the word offset, or the single uncached beat).
  - RESP: resp_valid=1. Hold resp_data and resp_err stable until resp_ready. Then go to IDLE.
  - In LOOKUP-hit, resp_ready=1 returns to IDLE the same cycle. resp_ready=0 stays in LOOKUP, output stable.
- Errors:
  - Any rresp!=0, or rlast early or late relative to arlen, sets resp_err=1 and suppresses install.
  - The burst is always drained to rlast before RESP.
- Line replacement: a refill overwrites the indexed line unconditionally; the old line is lost.
- Flush:
  - In IDLE: all valid bits clear on the next edge, and req_ready=0 in that cycle.
  - In any other state: flush sets pending-flush. Invalidation happens on entry to IDLE and takes precedence over installing the current line.
  - Simultaneous flush and req_valid in IDLE: flush wins; the request is accepted in a later cycle.
- Reset mid-burst: state returns to IDLE asynchronously and outstanding R beats are not tracked. The arbiter is reset together with the cache.
- Only one outstanding AXI transaction at any time.

Optional Feature:
- ICACHE_PERF_EN: adds outputs perf_hit[32] and perf_miss[32].
  - Counters reset to 0.
  - perf_hit increments on a LOOKUP hit handshake.
  - perf_miss increments on each cached-miss AR handshake.
  - Uncached accesses are counted in neither.
  - Counters saturate at 0xFFFF_FFFF.
- Without the macro: ports and counters are absent.

Test Plan:
- Cold miss, req 0x3000_0014:
  - Expect AR araddr=0x3000_0010, arlen=3.
  - Return beats 0x11,0x22,0x33,0x44; expect resp_data=0x22, resp_err=0.
- Re-request 0x3000_001C after that fill: no AR; resp_valid=1 one cycle after accept; resp_data=0x44.
- Conflict, req 0x3000_0114 (same index 1): miss refill replaces the line. Then req 0x3000_0014 misses again (new AR 0x3000_0010).
- Error refill: second beat rresp=2'b10 → resp_err=1 after rlast. Repeat same address → new AR (line not installed).
- Flush during refill: pulse flush in R state → current response still delivered. Next request to the same line issues a new AR.
- Uncached req 0x1000_0004: AR araddr=0x1000_0004, arlen=0. Returned beat 0xABCD is delivered; repeat issues another AR.
